// File: rtl/downd_lane_ctrl.sv
// -----------------------------------------------------------------------------
// downd_lane_ctrl
//   Sequencing controller for a 2:1 width-down FIFO built from two narrow
//   half-FIFOs (lane 0 / lane 1, SIZE/2 entries each). It steers one or two
//   narrow words per cycle into the lanes in strict round-robin order, pops one
//   narrow word per cycle alternating lanes, owns the single occupancy count and
//   produces every aggregate status flag. It holds no data.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i[1:0]   : 01 = one word (low half), 11 = two words (low first), 10 illegal
//   pop_i         : pop one narrow word
//   lane_push_o   : per-lane push strobes (same cycle as accepted push)
//   lane_swap_o   : 1 = low half of write data goes to lane 1, high half to lane 0
//   lane_pop_o    : per-lane pop strobes (same cycle as accepted pop)
//   rd_sel_o      : lane driving the read mux, aligned with valid_o
//   full_o        : [0] cannot take 1 word, [1] cannot take 2 words
//   empty_o       : no words stored
//   al_full_o     : [0] free <= AL_FULL, [1] free <= AL_FULL+1
//   al_empty_o    : stored <= AL_EMPTY
//   ack_o         : write accepted in the previous cycle
//   valid_o       : read data valid this cycle
//   err_o         : sticky overflow / underflow / illegal-push indicator
// -----------------------------------------------------------------------------
module downd_lane_ctrl #(
    parameter int SIZE     = 32,
    parameter int AL_FULL  = 2,
    parameter int AL_EMPTY = 2,
    parameter int ACK      = 1,
    parameter int VALID    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] push_i,
    input  logic       pop_i,
    output logic [1:0] lane_push_o,
    output logic       lane_swap_o,
    output logic [1:0] lane_pop_o,
    output logic       rd_sel_o,
    output logic [1:0] full_o,
    output logic       empty_o,
    output logic [1:0] al_full_o,
    output logic       al_empty_o,
    output logic       ack_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int CW = $clog2(SIZE + 1);

    localparam logic [CW-1:0] SIZE_C     = CW'(SIZE);
    localparam logic [CW-1:0] SIZE_M1_C  = CW'(SIZE - 1);
    localparam logic [CW-1:0] AL_FULL_C  = CW'(AL_FULL);
    localparam logic [CW-1:0] AL_FULL1_C = CW'(AL_FULL + 1);
    localparam logic [CW-1:0] AL_EMPTY_C = CW'(AL_EMPTY);

    logic [CW-1:0] count_q, count_d;
    logic          wr_lane_q, wr_lane_d;
    logic          rd_lane_q, rd_lane_d;
    logic          err_q, err_d;
    logic          ack_q, ack_d;
    logic          valid_q, valid_d;
    logic          rd_sel_q, rd_sel_d;

    logic [CW-1:0] free_s;
    logic [1:0]    wr_words_s;
    logic          wr_bad_s;
    logic          pop_acc_s;
    logic          rd_bad_s;

    // Status flags depend only on the registered count, never on this cycle's requests.
    assign free_s      = SIZE_C - count_q;
    assign full_o[0]   = (count_q == SIZE_C);
    assign full_o[1]   = (count_q >= SIZE_M1_C);
    assign empty_o     = (count_q == {CW{1'b0}});
    assign al_empty_o  = (count_q <= AL_EMPTY_C);
    assign al_full_o[0] = (free_s <= AL_FULL_C);
    assign al_full_o[1] = (free_s <= AL_FULL1_C);

    assign ack_o    = ack_q;
    assign valid_o  = valid_q;
    assign rd_sel_o = rd_sel_q;
    assign err_o    = err_q;

    // Write-side steering: a two-word push is all-or-nothing and keeps the write pointer.
    always_comb begin
        lane_push_o = 2'b00;
        lane_swap_o = 1'b0;
        wr_lane_d   = wr_lane_q;
        wr_words_s  = 2'd0;
        wr_bad_s    = 1'b0;
        case (push_i)
            2'b00: begin
                wr_words_s = 2'd0;
            end
            2'b01: begin
                if (!full_o[0]) begin
                    lane_push_o[wr_lane_q] = 1'b1;
                    lane_swap_o            = wr_lane_q;
                    wr_lane_d              = ~wr_lane_q;
                    wr_words_s             = 2'd1;
                end else begin
                    wr_bad_s = 1'b1;
                end
            end
            2'b11: begin
                if (!full_o[1]) begin
                    lane_push_o = 2'b11;
                    lane_swap_o = wr_lane_q;
                    wr_words_s  = 2'd2;
                end else begin
                    wr_bad_s = 1'b1;
                end
            end
            default: begin
                wr_bad_s = 1'b1;
            end
        endcase
    end

    // Read-side sequencing: a pop is judged on the start-of-cycle count, so a
    // same-cycle push never rescues a pop from an empty FIFO.
    always_comb begin
        lane_pop_o = 2'b00;
        rd_lane_d  = rd_lane_q;
        pop_acc_s  = 1'b0;
        rd_bad_s   = 1'b0;
        if (pop_i) begin
            if (!empty_o) begin
                lane_pop_o[rd_lane_q] = 1'b1;
                rd_lane_d             = ~rd_lane_q;
                pop_acc_s             = 1'b1;
            end else begin
                rd_bad_s = 1'b1;
            end
        end else begin
            pop_acc_s = 1'b0;
        end
    end

    // Next-state for count, sticky error and the one-cycle-late handshake outputs.
    always_comb begin
        count_d  = count_q + CW'(wr_words_s) - CW'(pop_acc_s);
        err_d    = err_q | wr_bad_s | rd_bad_s;
        ack_d    = (ACK != 0) ? (wr_words_s != 2'd0) : 1'b0;
        valid_d  = (VALID != 0) ? pop_acc_s : 1'b0;
        // rd_sel follows the half-FIFO read latency: it names the lane popped last cycle.
        rd_sel_d = pop_acc_s ? rd_lane_q : rd_sel_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= {CW{1'b0}};
            wr_lane_q <= 1'b0;
            rd_lane_q <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_lane_q <= wr_lane_d;
            rd_lane_q <= rd_lane_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

endmodule

// File: tb/tb_downd_lane_ctrl.sv
// -----------------------------------------------------------------------------
// tb_downd_lane_ctrl
//   Table-driven bench for downd_lane_ctrl (SIZE=8, AL_FULL=2, AL_EMPTY=2).
//   Each row gives the request for one cycle and the outputs expected in that
//   cycle (flags / ack / valid / rd_sel / err reflect the state at cycle start).
//   Two behavioural half-FIFOs are fed from the DUT strobes; words expected to be
//   accepted are queued when driven and compared when valid_o shows them.
// -----------------------------------------------------------------------------
module tb_downd_lane_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] push_i;
    logic       pop_i;
    logic [1:0] lane_push_o;
    logic       lane_swap_o;
    logic [1:0] lane_pop_o;
    logic       rd_sel_o;
    logic [1:0] full_o;
    logic       empty_o;
    logic [1:0] al_full_o;
    logic       al_empty_o;
    logic       ack_o;
    logic       valid_o;
    logic       err_o;

    downd_lane_ctrl #(
        .SIZE    (8),
        .AL_FULL (2),
        .AL_EMPTY(2),
        .ACK     (1),
        .VALID   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_i),
        .pop_i      (pop_i),
        .lane_push_o(lane_push_o),
        .lane_swap_o(lane_swap_o),
        .lane_pop_o (lane_pop_o),
        .rd_sel_o   (rd_sel_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .al_full_o  (al_full_o),
        .al_empty_o (al_empty_o),
        .ack_o      (ack_o),
        .valid_o    (valid_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] push;
        logic       pop;
        logic [1:0] lp;
        logic       sw;
        logic [1:0] lpop;
        logic [1:0] full;
        logic       empty;
        logic [1:0] alf;
        logic       ale;
        logic       ack;
        logic       valid;
        logic       rsel;
        logic       err;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int next_id = 100;
    int wlo, whi;
    int exp_q[$];
    int lane0_q[$];
    int lane1_q[$];
    int rdata0, rdata1;
    vec_t tbl[25];
    vec_t hs[7];

    function automatic vec_t mk(input logic [1:0] push, input logic pop,
                                input logic [1:0] lp, input logic sw, input logic [1:0] lpop,
                                input logic [1:0] full, input logic empty,
                                input logic [1:0] alf, input logic ale,
                                input logic ack, input logic valid, input logic rsel,
                                input logic err);
        vec_t v;
        v.push = push; v.pop = pop; v.lp = lp; v.sw = sw; v.lpop = lpop;
        v.full = full; v.empty = empty; v.alf = alf; v.ale = ale;
        v.ack = ack; v.valid = valid; v.rsel = rsel; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " lane_push"}, int'(lane_push_o), 0);
        chk({tag, " lane_pop"},  int'(lane_pop_o), 0);
        chk({tag, " full"},      int'(full_o), 0);
        chk({tag, " empty"},     int'(empty_o), 1);
        chk({tag, " al_full"},   int'(al_full_o), 0);
        chk({tag, " al_empty"},  int'(al_empty_o), 1);
        chk({tag, " ack"},       int'(ack_o), 0);
        chk({tag, " valid"},     int'(valid_o), 0);
        chk({tag, " rd_sel"},    int'(rd_sel_o), 0);
        chk({tag, " err"},       int'(err_o), 0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        lane0_q.delete();
        lane1_q.delete();
        rdata0 = 0;
        rdata1 = 0;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int got;
        int ld;
        @(negedge clk);
        push_i = v.push;
        pop_i  = v.pop;
        wlo = next_id;
        whi = next_id + 1;
        next_id += 2;
        // Expected write order: low half, then high half when a pair is accepted.
        if (v.lp != 2'b00) begin
            exp_q.push_back(wlo);
            if (v.push == 2'b11) exp_q.push_back(whi);
        end
        #1;
        chk({tag, " lane_push"}, int'(lane_push_o), int'(v.lp));
        chk({tag, " lane_swap"}, int'(lane_swap_o), int'(v.sw));
        chk({tag, " lane_pop"},  int'(lane_pop_o), int'(v.lpop));
        chk({tag, " full"},      int'(full_o), int'(v.full));
        chk({tag, " empty"},     int'(empty_o), int'(v.empty));
        chk({tag, " al_full"},   int'(al_full_o), int'(v.alf));
        chk({tag, " al_empty"},  int'(al_empty_o), int'(v.ale));
        chk({tag, " ack"},       int'(ack_o), int'(v.ack));
        chk({tag, " valid"},     int'(valid_o), int'(v.valid));
        chk({tag, " rd_sel"},    int'(rd_sel_o), int'(v.rsel));
        chk({tag, " err"},       int'(err_o), int'(v.err));
        // Scoreboard: data appearing on the read mux this cycle.
        if (valid_o) begin
            got = rd_sel_o ? rdata1 : rdata0;
            if (exp_q.size() == 0) begin
                chk({tag, " rdata (no word expected)"}, got, -1);
            end else begin
                chk({tag, " rdata order"}, got, exp_q.pop_front());
            end
        end
        // Half-FIFO models: read first (1-cycle latency), then write.
        if (lane_pop_o[0]) begin
            if (lane0_q.size() == 0) chk({tag, " lane0 underflow"}, 1, 0);
            else rdata0 = lane0_q.pop_front();
        end
        if (lane_pop_o[1]) begin
            if (lane1_q.size() == 0) chk({tag, " lane1 underflow"}, 1, 0);
            else rdata1 = lane1_q.pop_front();
        end
        if (lane_push_o[0]) lane0_q.push_back((lane_swap_o == 1'b0) ? wlo : whi);
        if (lane_push_o[1]) lane1_q.push_back((lane_swap_o == 1'b1) ? wlo : whi);
        ld = lane0_q.size() - lane1_q.size();
        chk({tag, " lane balance"}, int'(ld >= -1 && ld <= 1), 1);
    endtask

    initial begin
        // Ordering: A, (B,C), D, then four pops.
        tbl[0]  = mk(2'b01,1'b0, 2'b01,1'b0,2'b00, 2'b00,1'b1,2'b00,1'b1, 1'b0,1'b0,1'b0,1'b0);
        tbl[1]  = mk(2'b11,1'b0, 2'b11,1'b1,2'b00, 2'b00,1'b0,2'b00,1'b1, 1'b1,1'b0,1'b0,1'b0);
        tbl[2]  = mk(2'b01,1'b0, 2'b10,1'b1,2'b00, 2'b00,1'b0,2'b00,1'b0, 1'b1,1'b0,1'b0,1'b0);
        tbl[3]  = mk(2'b00,1'b1, 2'b00,1'b0,2'b01, 2'b00,1'b0,2'b00,1'b0, 1'b1,1'b0,1'b0,1'b0);
        tbl[4]  = mk(2'b00,1'b1, 2'b00,1'b0,2'b10, 2'b00,1'b0,2'b00,1'b0, 1'b0,1'b1,1'b0,1'b0);
        tbl[5]  = mk(2'b00,1'b1, 2'b00,1'b0,2'b01, 2'b00,1'b0,2'b00,1'b1, 1'b0,1'b1,1'b1,1'b0);
        tbl[6]  = mk(2'b00,1'b1, 2'b00,1'b0,2'b10, 2'b00,1'b0,2'b00,1'b1, 1'b0,1'b1,1'b0,1'b0);
        tbl[7]  = mk(2'b00,1'b0, 2'b00,1'b0,2'b00, 2'b00,1'b1,2'b00,1'b1, 1'b0,1'b1,1'b1,1'b0);
        // Fill to the top, reject an unsplittable pair, then push+pop at full.
        tbl[8]  = mk(2'b11,1'b0, 2'b11,1'b0,2'b00, 2'b00,1'b1,2'b00,1'b1, 1'b0,1'b0,1'b1,1'b0);
        tbl[9]  = mk(2'b11,1'b0, 2'b11,1'b0,2'b00, 2'b00,1'b0,2'b00,1'b1, 1'b1,1'b0,1'b1,1'b0);
        tbl[10] = mk(2'b11,1'b0, 2'b11,1'b0,2'b00, 2'b00,1'b0,2'b00,1'b0, 1'b1,1'b0,1'b1,1'b0);
        tbl[11] = mk(2'b01,1'b0, 2'b01,1'b0,2'b00, 2'b00,1'b0,2'b11,1'b0, 1'b1,1'b0,1'b1,1'b0);
        tbl[12] = mk(2'b11,1'b0, 2'b00,1'b0,2'b00, 2'b10,1'b0,2'b11,1'b0, 1'b1,1'b0,1'b1,1'b0);
        tbl[13] = mk(2'b01,1'b0, 2'b10,1'b1,2'b00, 2'b10,1'b0,2'b11,1'b0, 1'b0,1'b0,1'b1,1'b1);
        tbl[14] = mk(2'b01,1'b1, 2'b00,1'b0,2'b01, 2'b11,1'b0,2'b11,1'b0, 1'b1,1'b0,1'b1,1'b1);
        // Drain the remaining seven words.
        tbl[15] = mk(2'b00,1'b1, 2'b00,1'b0,2'b10, 2'b10,1'b0,2'b11,1'b0, 1'b0,1'b1,1'b0,1'b1);
        tbl[16] = mk(2'b00,1'b1, 2'b00,1'b0,2'b01, 2'b00,1'b0,2'b11,1'b0, 1'b0,1'b1,1'b1,1'b1);
        tbl[17] = mk(2'b00,1'b1, 2'b00,1'b0,2'b10, 2'b00,1'b0,2'b10,1'b0, 1'b0,1'b1,1'b0,1'b1);
        tbl[18] = mk(2'b00,1'b1, 2'b00,1'b0,2'b01, 2'b00,1'b0,2'b00,1'b0, 1'b0,1'b1,1'b1,1'b1);
        tbl[19] = mk(2'b00,1'b1, 2'b00,1'b0,2'b10, 2'b00,1'b0,2'b00,1'b0, 1'b0,1'b1,1'b0,1'b1);
        tbl[20] = mk(2'b00,1'b1, 2'b00,1'b0,2'b01, 2'b00,1'b0,2'b00,1'b1, 1'b0,1'b1,1'b1,1'b1);
        tbl[21] = mk(2'b00,1'b1, 2'b00,1'b0,2'b10, 2'b00,1'b0,2'b00,1'b1, 1'b0,1'b1,1'b0,1'b1);
        // Empty pop with a same-cycle pair push (no write-through), illegal push, idle.
        tbl[22] = mk(2'b11,1'b1, 2'b11,1'b0,2'b00, 2'b00,1'b1,2'b00,1'b1, 1'b0,1'b1,1'b1,1'b1);
        tbl[23] = mk(2'b10,1'b0, 2'b00,1'b0,2'b00, 2'b00,1'b0,2'b00,1'b1, 1'b1,1'b0,1'b1,1'b1);
        tbl[24] = mk(2'b00,1'b0, 2'b00,1'b0,2'b00, 2'b00,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b1,1'b1);

        // Build count=5, then ack latency: one cycle high, then low.
        hs[0] = mk(2'b11,1'b0, 2'b11,1'b0,2'b00, 2'b00,1'b1,2'b00,1'b1, 1'b0,1'b0,1'b0,1'b0);
        hs[1] = mk(2'b11,1'b0, 2'b11,1'b0,2'b00, 2'b00,1'b0,2'b00,1'b1, 1'b1,1'b0,1'b0,1'b0);
        hs[2] = mk(2'b01,1'b0, 2'b01,1'b0,2'b00, 2'b00,1'b0,2'b00,1'b0, 1'b1,1'b0,1'b0,1'b0);
        hs[3] = mk(2'b00,1'b0, 2'b00,1'b0,2'b00, 2'b00,1'b0,2'b10,1'b0, 1'b1,1'b0,1'b0,1'b0);
        hs[4] = mk(2'b00,1'b0, 2'b00,1'b0,2'b00, 2'b00,1'b0,2'b10,1'b0, 1'b0,1'b0,1'b0,1'b0);
        // After the mid-stream reset: illegal push from a clean state.
        hs[5] = mk(2'b10,1'b0, 2'b00,1'b0,2'b00, 2'b00,1'b1,2'b00,1'b1, 1'b0,1'b0,1'b0,1'b0);
        hs[6] = mk(2'b00,1'b0, 2'b00,1'b0,2'b00, 2'b00,1'b1,2'b00,1'b1, 1'b0,1'b0,1'b0,1'b1);

        rst_n  = 1'b0;
        push_i = 2'b00;
        pop_i  = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("reset");

        for (int i = 0; i < 25; i++) begin
            apply_vec($sformatf("row%0d", i), tbl[i]);
        end

        // Asynchronous reset while err=1 and words are pending.
        @(negedge clk);
        push_i = 2'b00;
        pop_i  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset1");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply_vec($sformatf("seq%0d", i), hs[i]);
        end

        // Mid-stream async reset at count=5, between clock edges.
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset_mid");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 5; i < 7; i++) begin
            apply_vec($sformatf("seq%0d", i), hs[i]);
        end

        chk("scoreboard drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
